// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between the core and the buffered UART transmitter.
// The core is the master; the transmitter's FIFO is the slave.
interface uart_tx_fifo_if;
  logic       wr_vld;
  logic [7:0] wr_data;
  logic       wr_rdy;

  modport master (output wr_vld, output wr_data, input wr_rdy);
  modport slave  (input wr_vld, input wr_data, output wr_rdy);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO of 8-bit words feeds a frame FSM
// that emits start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 wr,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(DIVISOR - 1);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO   = (AW+1)'(0);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic          ODD        = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          empty;

  state_t        state;
  state_t        next_state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    tx_data;
  logic          tx_next;
  logic          bit_end;
  logic          stop_last;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign push       = wr.wr_vld & wr.wr_rdy;
  assign empty      = (count == CNT_ZERO);
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign stop_last  = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign fifo_count = count;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage array; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr.wr_data;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= CNT_ZERO;
      wr.wr_rdy <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count     <= count_next;
      wr.wr_rdy <= (count_next != FULL_COUNT);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, FIFO pop and the next line level; pop only sees the registered empty flag.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tx_next    = tx;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          tx_next    = 1'b0;
          next_state = START;
        end else begin
          next_state = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          tx_next    = tx_data[0];
          next_state = DATA;
        end else begin
          tx_next = 1'b0;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          if (PARITY_EN != 0) begin
            tx_next    = parity_bit(tx_data, ODD);
            next_state = PARITY;
          end else begin
            tx_next    = 1'b1;
            next_state = STOP;
          end
        end else if (bit_end) begin
          tx_next = tx_data[bit_idx + 3'd1];
        end else begin
          tx_next = tx_data[bit_idx];
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_next    = 1'b1;
          next_state = STOP;
        end else begin
          tx_next = parity_bit(tx_data, ODD);
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_end && stop_last) begin
          if (!empty) begin
            pop        = 1'b1;
            tx_next    = 1'b0;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = STOP;
        end
      end
      default: begin
        tx_next    = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  // Line output, busy flag, bit timing counters and the word being shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx   <= tx_next;
      busy <= (next_state != IDLE);
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
      if ((state == IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_ONE;
      end
      if ((state == DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end else if (state != DATA) begin
        bit_idx <= 3'd0;
      end
      if ((state == STOP) && bit_end && !stop_last) begin
        stop_idx <= 1'b1;
      end else if ((state != STOP) || bit_end) begin
        stop_idx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations checked every cycle against a
// frame-level queue model, plus literal checks on hand-computed line levels.
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       vld   [3];
  logic [7:0] dat   [3];
  logic       tx_o  [3];
  logic       busy_o[3];
  logic [4:0] cnt_o [3];
  logic       rdy_o [3];

  // Instance 0: even parity, 1 stop; 1: no parity, 1 stop; 2: odd parity, 2 stops.
  logic [2:0] pe_v  = 3'b101;
  logic [2:0] odd_v = 3'b100;
  logic [2:0] sb2_v = 3'b100;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if ifc0 ();
  uart_tx_fifo_if ifc1 ();
  uart_tx_fifo_if ifc2 ();

  assign ifc0.wr_vld = vld[0];
  assign ifc0.wr_data = dat[0];
  assign rdy_o[0] = ifc0.wr_rdy;
  assign ifc1.wr_vld = vld[1];
  assign ifc1.wr_data = dat[1];
  assign rdy_o[1] = ifc1.wr_rdy;
  assign ifc2.wr_vld = vld[2];
  assign ifc2.wr_data = dat[2];
  assign rdy_o[2] = ifc2.wr_rdy;

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .wr(ifc0.slave), .tx(tx_o[0]), .busy(busy_o[0]), .fifo_count(cnt_o[0]));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .wr(ifc1.slave), .tx(tx_o[1]), .busy(busy_o[1]), .fifo_count(cnt_o[1]));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr(ifc2.slave), .tx(tx_o[2]), .busy(busy_o[2]), .fifo_count(cnt_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queued words, the word on the line and how many clocks into its frame.
  logic [7:0] mq  [3][$];
  logic [7:0] cur [3];
  int         pos [3];
  bit         act [3];

  function automatic int flen(input int i);
    return (9 + int'(pe_v[i]) + (sb2_v[i] ? 2 : 1)) * DIV;
  endfunction

  function automatic logic fbit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((b == 9) && pe_v[i]) return (^d) ^ odd_v[i];
    return 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      pos[i] = 0;
      cur[i] = 8'h00;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          mq[i].delete();
          act[i] = 1'b0;
          pos[i] = 0;
        end else begin
          int  n;
          bit  room;
          n    = mq[i].size();
          room = (n < DEPTH);
          if (act[i]) begin
            pos[i]++;
            if (pos[i] == flen(i)) begin
              if (n > 0) begin
                cur[i] = mq[i].pop_front();
                pos[i] = 0;
              end else begin
                act[i] = 1'b0;
              end
            end
          end else if (n > 0) begin
            cur[i] = mq[i].pop_front();
            pos[i] = 0;
            act[i] = 1'b1;
          end
          if (vld[i] && room) mq[i].push_back(dat[i]);
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        logic etx;
        etx = act[i] ? fbit(i, cur[i], pos[i] / DIV) : 1'b1;
        check($sformatf("model_tx%0d", i), 32'(tx_o[i]), 32'(etx));
        check($sformatf("model_busy%0d", i), 32'(busy_o[i]), 32'(act[i]));
        check($sformatf("model_cnt%0d", i), 32'(cnt_o[i]), 32'(mq[i].size()));
        check($sformatf("model_rdy%0d", i), 32'(rdy_o[i]), 32'(mq[i].size() < DEPTH));
      end
    end
  end

  task automatic put(input int i, input logic [7:0] d);
    vld[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  initial begin
    logic [9:0] seq55;
    int         lows;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    check("reset_tx", 32'(tx_o[0]), 32'd1);
    check("reset_rdy", 32'(rdy_o[0]), 32'd1);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    check("reset_cnt", 32'(cnt_o[0]), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // No parity: 0x55 gives an alternating line, 160 clocks long.
    seq55 = 10'b1010101010;
    put(1, 8'h55);
    @(negedge clk);
    repeat (8) @(negedge clk);
    check("p0_bit0", 32'(tx_o[1]), 32'(seq55[0]));
    for (int j = 1; j < 10; j++) begin
      repeat (16) @(negedge clk);
      check($sformatf("p0_bit%0d", j), 32'(tx_o[1]), 32'(seq55[j]));
    end
    repeat (7) @(negedge clk);
    check("p0_busy_159", 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    check("p0_busy_160", 32'(busy_o[1]), 32'd0);

    // 0x07: even parity bit 1, odd parity bit 0; two stop bits hold 32 clocks.
    vld[0] = 1'b1; dat[0] = 8'h07;
    vld[2] = 1'b1; dat[2] = 8'h07;
    @(negedge clk);
    vld[0] = 1'b0; vld[2] = 1'b0;
    @(negedge clk);
    repeat (152) @(negedge clk);
    check("even_parity", 32'(tx_o[0]), 32'd1);
    check("odd_parity", 32'(tx_o[2]), 32'd0);
    for (int p = 153; p <= 200; p++) begin
      @(negedge clk);
      if (p >= 160 && p <= 191) check("stop2_high", 32'(tx_o[2]), 32'd1);
      if (p == 175) check("sb1_busy_175", 32'(busy_o[0]), 32'd1);
      if (p == 176) check("sb1_busy_176", 32'(busy_o[0]), 32'd0);
      if (p == 191) check("sb2_busy_191", 32'(busy_o[2]), 32'd1);
      if (p == 192) check("sb2_busy_192", 32'(busy_o[2]), 32'd0);
    end

    // Three words on consecutive edges: back-to-back frames, count peaks at 2.
    vld[0] = 1'b1; dat[0] = 8'hA5;
    @(negedge clk);
    dat[0] = 8'h3C;
    @(negedge clk);
    dat[0] = 8'hFF;
    @(negedge clk);
    vld[0] = 1'b0;
    check("b2b_peak_cnt", 32'(cnt_o[0]), 32'd2);
    repeat (526) @(negedge clk);
    check("b2b_busy_527", 32'(busy_o[0]), 32'd1);
    @(negedge clk);
    check("b2b_busy_528", 32'(busy_o[0]), 32'd0);
    repeat (4) @(negedge clk);

    // Twenty writes: 17 accepted, last three dropped.
    vld[1] = 1'b1;
    for (int w = 0; w < 20; w++) begin
      dat[1] = 8'(w * 13 + 1);
      @(negedge clk);
    end
    vld[1] = 1'b0;
    check("full_rdy", 32'(rdy_o[1]), 32'd0);
    check("full_cnt", 32'(cnt_o[1]), 32'd16);
    repeat (17 * 160) @(negedge clk);
    check("drain_busy", 32'(busy_o[1]), 32'd0);
    check("drain_cnt", 32'(cnt_o[1]), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during data bit 3 with four words queued.
    vld[0] = 1'b1;
    for (int w = 0; w < 5; w++) begin
      dat[0] = 8'(w * 17);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    check("pre_rst_cnt", 32'(cnt_o[0]), 32'd4);
    repeat (69) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx_o[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx_o[0]), 32'd1);
    check("rst_async_cnt", 32'(cnt_o[0]), 32'd0);
    check("rst_async_busy", 32'(busy_o[0]), 32'd0);
    check("rst_async_rdy", 32'(rdy_o[0]), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1) lows++;
    end
    check("post_rst_no_frame", 32'(lows), 32'd0);
    check("post_rst_busy", 32'(busy_o[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
